// File: rtl/synth_cfg_pkg.sv
// Shared constants for the synth SPI configuration slave: register map,
// reset defaults, frame layout and FSM encoding.
package synth_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  // Bit counter landmarks: header complete, full frame, saturation value.
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = 5'd7;
  localparam logic [CNT_W-1:0] CNT_HDR_DONE = 5'd8;
  localparam logic [CNT_W-1:0] CNT_FULL     = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT      = 5'd17;

  // Once 8 bits are in, the W bit sits at the top of the low byte.
  localparam int HDR_W_BIT = 7;

  localparam logic [3:0] REG_AI     = 4'h0;
  localparam logic [3:0] REG_DI     = 4'h1;
  localparam logic [3:0] REG_S      = 4'h2;
  localparam logic [3:0] REG_RI     = 4'h3;
  localparam logic [3:0] REG_OSC_LO = 4'h4;
  localparam logic [3:0] REG_OSC_HI = 4'h5;
  localparam logic [3:0] REG_FA     = 4'h6;
  localparam logic [3:0] REG_FB     = 4'h7;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_ID     = 4'h9;

  localparam logic [7:0]  RST_AI        = 8'h10;
  localparam logic [7:0]  RST_DI        = 8'h10;
  localparam logic [7:0]  RST_S         = 8'h80;
  localparam logic [7:0]  RST_RI        = 8'h10;
  localparam logic [11:0] RST_OSC_COUNT = 12'h200;
  localparam logic [7:0]  RST_OSC_LO    = 8'h00;
  localparam logic [7:0]  RST_FILTER_A  = 8'h40;
  localparam logic [7:0]  RST_FILTER_B  = 8'h40;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef struct packed {
    logic       wr;
    logic [2:0] rsvd;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous SPI pin with rise/fall
// detection on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/synth_spi_cfg.sv
// SPI mode-0 slave register file driving the synth core configuration.
// All pins are oversampled in the clk domain; 16-bit W/addr/data frames.
module synth_spi_cfg
  import synth_cfg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CHIP_ID     = 8'hCD
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [7:0]  adsr_ai,
  output logic [7:0]  adsr_di,
  output logic [7:0]  adsr_s,
  output logic [7:0]  adsr_ri,
  output logic [11:0] osc_count,
  output logic [7:0]  filter_a,
  output logic [7:0]  filter_b,
  output logic        trig,
  output logic        cfg_update
);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rstn  (rstn),
    .din   (spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rstn  (rstn),
    .din   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Same depth as the sck path so MOSI lines up with the detected rise.
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   mosi_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mosi_sync_reg <= '0;
    else       mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] shift_next;
  logic [7:0]            rdata_reg;
  logic                  is_read_reg;
  logic                  miso_reg;
  logic                  cfg_update_reg;

  logic [7:0]  ai_reg, di_reg, s_reg, ri_reg;
  logic [11:0] osc_count_reg;
  logic [7:0]  osc_lo_reg;
  logic [7:0]  fa_reg, fb_reg;
  logic        trig_reg;

  frame_t     cur_frame;
  logic [3:0] hdr_addr;
  logic [7:0] rd_mux;
  logic       commit_en;
  logic       addr_writable;

  assign shift_next = {shift_reg[FRAME_BITS-2:0], mosi_s};
  assign cur_frame  = shift_reg;
  assign hdr_addr   = shift_next[3:0];

  always_comb begin
    rd_mux = 8'h00;
    case (hdr_addr)
      REG_AI:     rd_mux = ai_reg;
      REG_DI:     rd_mux = di_reg;
      REG_S:      rd_mux = s_reg;
      REG_RI:     rd_mux = ri_reg;
      REG_OSC_LO: rd_mux = osc_lo_reg;
      REG_OSC_HI: rd_mux = {4'h0, osc_count_reg[11:8]};
      REG_FA:     rd_mux = fa_reg;
      REG_FB:     rd_mux = fb_reg;
      REG_CTRL:   rd_mux = {7'h00, trig_reg};
      REG_ID:     rd_mux = CHIP_ID;
      default:    rd_mux = 8'h00;
    endcase
  end

  assign commit_en     = (state_reg == ST_COMMIT) && (cnt_reg == CNT_FULL) && cur_frame.wr;
  assign addr_writable = (cur_frame.addr <= REG_CTRL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      rdata_reg      <= '0;
      is_read_reg    <= 1'b0;
      miso_reg       <= 1'b0;
      cfg_update_reg <= 1'b0;
    end else begin
      cfg_update_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          miso_reg <= 1'b0;
          if (cs_fall) begin
            cnt_reg     <= '0;
            is_read_reg <= 1'b0;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            shift_reg <= shift_next;
            cnt_reg   <= sat_inc(cnt_reg);
            if (cnt_reg == CNT_HDR_LAST) begin
              rdata_reg   <= rd_mux;
              is_read_reg <= ~shift_next[HDR_W_BIT];
            end
          end
          // Read data goes out MSB first on the falls between rise 8 and rise 16.
          if (sck_fall) begin
            if (is_read_reg && (cnt_reg >= CNT_HDR_DONE) && (cnt_reg < CNT_FULL)) begin
              miso_reg  <= rdata_reg[7];
              rdata_reg <= {rdata_reg[6:0], 1'b0};
            end else begin
              miso_reg <= 1'b0;
            end
          end
          // A simultaneous sck rise is absorbed above before the commit decision.
          if (cs_rise) state_reg <= ST_COMMIT;
        end
        ST_COMMIT: begin
          miso_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
          cfg_update_reg <= commit_en && addr_writable;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ai_reg        <= RST_AI;
      di_reg        <= RST_DI;
      s_reg         <= RST_S;
      ri_reg        <= RST_RI;
      osc_count_reg <= RST_OSC_COUNT;
      osc_lo_reg    <= RST_OSC_LO;
      fa_reg        <= RST_FILTER_A;
      fb_reg        <= RST_FILTER_B;
      trig_reg      <= 1'b0;
    end else if (commit_en) begin
      case (cur_frame.addr)
        REG_AI:     ai_reg        <= cur_frame.data;
        REG_DI:     di_reg        <= cur_frame.data;
        REG_S:      s_reg         <= cur_frame.data;
        REG_RI:     ri_reg        <= cur_frame.data;
        REG_OSC_LO: osc_lo_reg    <= cur_frame.data;
        REG_OSC_HI: osc_count_reg <= {cur_frame.data[3:0], osc_lo_reg};
        REG_FA:     fa_reg        <= cur_frame.data;
        REG_FB:     fb_reg        <= cur_frame.data;
        REG_CTRL:   trig_reg      <= cur_frame.data[0];
        default:    ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cur_frame.rsvd, sck_level};

  assign spi_miso   = miso_reg & ~cs_level;
  assign adsr_ai    = ai_reg;
  assign adsr_di    = di_reg;
  assign adsr_s     = s_reg;
  assign adsr_ri    = ri_reg;
  assign osc_count  = osc_count_reg;
  assign filter_a   = fa_reg;
  assign filter_b   = fb_reg;
  assign trig       = trig_reg;
  assign cfg_update = cfg_update_reg;

endmodule

// File: tb/tb_synth_spi_cfg.sv
// Directed bench for synth_spi_cfg: table of SPI frames with expected
// readback/outputs, plus hand sequences for latency and mid-frame reset.
module tb_synth_spi_cfg;

  localparam int SYNC = 2;
  localparam int HALF = 8;
  localparam int GAP  = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [7:0]  adsr_ai, adsr_di, adsr_s, adsr_ri;
  logic [11:0] osc_count;
  logic [7:0]  filter_a, filter_b;
  logic        trig;
  logic        cfg_update;

  synth_spi_cfg #(.SYNC_STAGES(SYNC), .CHIP_ID(8'hCD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .adsr_ai    (adsr_ai),
    .adsr_di    (adsr_di),
    .adsr_s     (adsr_s),
    .adsr_ri    (adsr_ri),
    .osc_count  (osc_count),
    .filter_a   (filter_a),
    .filter_b   (filter_b),
    .trig       (trig),
    .cfg_update (cfg_update)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;
  logic prev_upd = 1'b0;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic [7:0]  exp_rd;
    int          sel;
    logic [11:0] exp_val;
    int          exp_pulses;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  // Count cfg_update pulses and insist each lasts exactly one cycle.
  always @(negedge clk) begin
    if (cfg_update) begin
      pulse_cnt++;
      n_vec++;
      if (prev_upd) begin
        n_err++;
        $display("FAIL cfg_update_width: got high 2+ cycles, required 1 cycle");
      end
    end
    prev_upd = cfg_update;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] get_sel(input int s);
    case (s)
      0: return {4'h0, adsr_ai};
      1: return {4'h0, adsr_di};
      2: return {4'h0, adsr_s};
      3: return {4'h0, adsr_ri};
      4: return osc_count;
      5: return {4'h0, filter_a};
      6: return {4'h0, filter_b};
      7: return {11'h000, trig};
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic spi_frame(input logic [15:0] word, input int nbits, input bit hold,
                           output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      if (i >= 8 && i < 16) rd = {rd[6:0], spi_miso};
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_mosi = 1'b0;
    if (!hold) begin
      spi_cs_n = 1'b1;
      repeat (GAP) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int p0;

    vt[0]  = '{16'h0900, 16, 8'hCD, 0, 12'h010, 0};
    vt[1]  = '{16'h0200, 16, 8'h80, 2, 12'h080, 0};
    vt[2]  = '{16'h8434, 16, 8'h00, 4, 12'h200, 1};
    vt[3]  = '{16'h0400, 16, 8'h34, 4, 12'h200, 0};
    vt[4]  = '{16'h0500, 16, 8'h02, 4, 12'h200, 0};
    vt[5]  = '{16'h85F1, 16, 8'h00, 4, 12'h134, 1};
    vt[6]  = '{16'h0500, 16, 8'h01, 4, 12'h134, 0};
    vt[7]  = '{16'h86AA, 12, 8'h00, 5, 12'h040, 0};
    vt[8]  = '{16'h86AA, 17, 8'h00, 5, 12'h040, 0};
    vt[9]  = '{16'h8655, 16, 8'h00, 5, 12'h055, 1};
    vt[10] = '{16'h879C, 16, 8'h00, 6, 12'h09C, 1};
    vt[11] = '{16'h8801, 16, 8'h00, 7, 12'h001, 1};
    vt[12] = '{16'h0800, 16, 8'h01, 7, 12'h001, 0};
    vt[13] = '{16'h8800, 16, 8'h00, 7, 12'h000, 1};
    vt[14] = '{16'h8CFF, 16, 8'h00, 6, 12'h09C, -1};
    vt[15] = '{16'h0C00, 16, 8'h00, 5, 12'h055, 0};
    vt[16] = '{16'h8912, 16, 8'h00, 7, 12'h000, -1};
    vt[17] = '{16'h0900, 16, 8'hCD, 6, 12'h09C, 0};
    vt[18] = '{16'hF307, 16, 8'h00, 3, 12'h007, 1};
    vt[19] = '{16'h85AB, 16, 8'h00, 4, 12'hB34, 1};
    vt[20] = '{16'h0500, 16, 8'h0B, 4, 12'hB34, 0};
    vt[21] = '{16'h0200, 12, 8'h08, 2, 12'h080, 0};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ai", {8'h00, adsr_ai}, 16'h0010);
    check("rst_di", {8'h00, adsr_di}, 16'h0010);
    check("rst_s", {8'h00, adsr_s}, 16'h0080);
    check("rst_ri", {8'h00, adsr_ri}, 16'h0010);
    check("rst_osc", {4'h0, osc_count}, 16'h0200);
    check("rst_fa", {8'h00, filter_a}, 16'h0040);
    check("rst_fb", {8'h00, filter_b}, 16'h0040);
    check("rst_trig", {15'h0, trig}, 16'h0000);
    check("rst_upd", {15'h0, cfg_update}, 16'h0000);
    check("rst_miso", {15'h0, spi_miso}, 16'h0000);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      p0 = pulse_cnt;
      spi_frame(vt[i].word, vt[i].nbits, 1'b0, rd);
      $display("vec %0d: frame 0x%04h bits %0d rd 0x%02h sel %0d val 0x%03h pulses %0d",
               i, vt[i].word, vt[i].nbits, rd, vt[i].sel, get_sel(vt[i].sel), pulse_cnt - p0);
      check($sformatf("vec%0d_rd", i), {8'h00, rd}, {8'h00, vt[i].exp_rd});
      check($sformatf("vec%0d_out", i), {4'h0, get_sel(vt[i].sel)}, {4'h0, vt[i].exp_val});
      check($sformatf("vec%0d_miso_idle", i), {15'h0, spi_miso}, 16'h0000);
      if (vt[i].exp_pulses >= 0)
        check($sformatf("vec%0d_pulses", i), 16'(pulse_cnt - p0), 16'(vt[i].exp_pulses));
    end

    // Commit latency measured from the pin-level cs_n rise.
    p0 = pulse_cnt;
    spi_frame(16'h803A, 16, 1'b1, rd);
    spi_cs_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("lat_ai_before", {8'h00, adsr_ai}, 16'h0010);
    check("lat_upd_before", {15'h0, cfg_update}, 16'h0000);
    @(negedge clk);
    check("lat_ai_at", {8'h00, adsr_ai}, 16'h003A);
    check("lat_upd_at", {15'h0, cfg_update}, 16'h0001);
    @(negedge clk);
    check("lat_upd_after", {15'h0, cfg_update}, 16'h0000);
    repeat (GAP) @(negedge clk);
    check("lat_pulses", 16'(pulse_cnt - p0), 16'd1);
    $display("latency: ai 0x%02h pulses %0d", adsr_ai, pulse_cnt - p0);

    // Reset in the middle of a write to di, after 10 bits.
    p0 = pulse_cnt;
    spi_frame(16'h8199, 10, 1'b1, rd);
    rstn = 1'b0;
    #1;
    check("mrst_ai", {8'h00, adsr_ai}, 16'h0010);
    check("mrst_di", {8'h00, adsr_di}, 16'h0010);
    check("mrst_osc", {4'h0, osc_count}, 16'h0200);
    check("mrst_fa", {8'h00, filter_a}, 16'h0040);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (GAP) @(negedge clk);
    check("mrst_di_after", {8'h00, adsr_di}, 16'h0010);
    check("mrst_pulses", 16'(pulse_cnt - p0), 16'd0);
    $display("mid-frame reset: di 0x%02h pulses %0d", adsr_di, pulse_cnt - p0);
    p0 = pulse_cnt;
    spi_frame(16'h8122, 16, 1'b0, rd);
    check("post_di", {8'h00, adsr_di}, 16'h0022);
    check("post_pulses", 16'(pulse_cnt - p0), 16'd1);
    $display("post-reset write: di 0x%02h pulses %0d", adsr_di, pulse_cnt - p0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
